cbus_arbiter: RTL and testbench
===============================

CBUS_ARBITER -- requirements
Module: cbus_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, number of cache-bus requesters (index 0 = DCache, 1 = ICache).
REQ-002 Parameter RR_ENABLE, default 1, 1 = round-robin priority, 0 = fixed priority with lowest index winning.
REQ-003 Port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Port reset  in  1  asynchronous, active-high reset.
REQ-005 Port ireqs  in  cbus_req_t[NUM_REQ]  per-requester cache-bus requests (valid, is_write, size, addr, strobe, data, len).
REQ-006 Port oresps  out  cbus_resp_t[NUM_REQ]  per-requester responses (ready, last, data).
REQ-007 Port oreq  out  cbus_req_t  request to the shared memory-side cache bus.
REQ-008 Port iresp  in  cbus_resp_t  response from the shared memory-side cache bus.
REQ-009 Port owner  out  log2(NUM_REQ) bits  index of the current grant holder; valid only while busy.
REQ-010 Port busy  out  1  high while a burst is granted.

Function
REQ-011 States: IDLE and BUSY; state, owner and priority pointer are registers.
REQ-012 IDLE: oreq SHALL be all-zero (valid=0), and every oresps entry SHALL be all-zero.
REQ-013 IDLE with at least one ireqs[i].valid: the winner is selected combinationally, captured into owner, and the next state is BUSY; arbitration latency is 1 cycle.
REQ-014 Round-robin: search starts at the priority pointer and wraps modulo NUM_REQ; the first valid index wins.
REQ-015 BUSY: oreq SHALL equal ireqs[owner] unmodified; oresps[owner] SHALL equal iresp; all other oresps SHALL be all-zero.
REQ-016 BUSY to IDLE when iresp.ready && iresp.last; that cycle's response is still forwarded to the owner.
REQ-017 On that transition with RR_ENABLE=1, the pointer becomes (owner+1) mod NUM_REQ; with RR_ENABLE=0 the pointer stays 0.
REQ-018 There is no back-to-back grant: after last, at least one IDLE cycle occurs before the next oreq.valid, so the memory side sees valid drop between bursts.
REQ-019 Grant is locked for the whole burst (len+1 beats); requests from non-owners are ignored until IDLE and require no ordering among themselves.
REQ-020 If the owner deasserts valid while BUSY, the arbiter remains BUSY, forwards oreq.valid=0, and waits for last; it never preempts.
REQ-021 A requester asserting valid in the same cycle that another's burst ends is eligible in the following IDLE cycle.
REQ-022 busy = (state==BUSY); owner holds its value until the next grant.

Reset
REQ-023 Reset forces state=IDLE, owner=0, pointer=0, busy=0, oreq all-zero, and all oresps all-zero.
REQ-024 Reset asserted mid-burst abandons the burst immediately; no response is forwarded in the reset cycle or after it.

Structure
REQ-025 The state enum (IDLE/BUSY) and the owner index type belong in the shared mycpu package/header beside the cbus typedefs.
REQ-026 cbus_req_t and cbus_resp_t are reused unchanged from the existing common header.
REQ-027 One sub-module is natural: rr_pick (NUM_REQ-wide round-robin priority encoder: valid vector + pointer -> one-hot/index + any).
REQ-028 Target size: 120-250 lines RTL in total.

Verification
REQ-029 Single request: ireqs[0] valid, len=3 (4 beats), memory gives ready on every cycle -> grant 1 cycle later, oresps[0] gets 4 beats, last on the 4th beat, IDLE on the next cycle.
REQ-030 Simultaneous requests, pointer=0: both valid -> 0 served first, then after 1 IDLE cycle 1 is served; with both still valid afterwards, 0 is served next (alternation 0,1,0,1).
REQ-031 RR_ENABLE=0: both continuously valid -> requester 0 is always granted; 1 starves, which is expected.
REQ-032 Isolation: during a burst owned by 1, oresps[0].ready stays 0 even though iresp.ready=1.
REQ-033 Owner drops valid mid-burst: oreq.valid=0 is forwarded, the arbiter stays BUSY until iresp.last.
REQ-034 Reset pulse at beat 2 of an 8-beat burst -> all outputs are zero the same cycle, IDLE follows, and a new request is granted normally afterwards.

Source files
------------

// File: rtl/cbus_arbiter_pkg.sv
// Shared cache-bus types for the requester/memory arbiter: request/response
// structs, the arbiter state encoding and the grant-index width helper.
package cbus_arbiter_pkg;

  localparam int CBUS_ADDR_W  = 32;
  localparam int CBUS_DATA_W  = 64;
  localparam int CBUS_STRB_W  = 8;
  localparam int CBUS_SIZE_W  = 3;
  localparam int CBUS_LEN_W   = 4;
  localparam int CBUS_NUM_REQ = 2;

  typedef struct packed {
    logic                   valid;
    logic                   is_write;
    logic [CBUS_SIZE_W-1:0] size;
    logic [CBUS_ADDR_W-1:0] addr;
    logic [CBUS_STRB_W-1:0] strobe;
    logic [CBUS_DATA_W-1:0] data;
    logic [CBUS_LEN_W-1:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic                   ready;
    logic                   last;
    logic [CBUS_DATA_W-1:0] data;
  } cbus_resp_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // A single requester still needs one bit to hold its index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [idx_w(CBUS_NUM_REQ)-1:0] cbus_owner_t;

endpackage

// File: rtl/cbus_arbiter_if.sv
// Bundle of requester-side and memory-side cache-bus signals around the arbiter.
// Handshake: a beat transfers on a cycle where the owner's request has valid=1
// and iresp.ready=1; iresp.last marks the final beat of the burst.
interface cbus_arbiter_if import cbus_arbiter_pkg::*; #(
  parameter int NUM_REQ = 2
);
  localparam int IW = idx_w(NUM_REQ);

  cbus_req_t     ireqs  [NUM_REQ];
  cbus_resp_t    oresps [NUM_REQ];
  cbus_req_t     oreq;
  cbus_resp_t    iresp;
  logic [IW-1:0] owner;
  logic          busy;
  arb_state_t    state;

  modport master (
    input  ireqs, iresp,
    output oresps, oreq, owner, busy, state
  );

  modport slave (
    output ireqs, iresp,
    input  oresps, oreq, owner, busy, state
  );
endinterface

// File: rtl/cbus_arbiter_rr_pick.sv
// Round-robin priority encoder: first set bit of valid_i at or after ptr_i,
// wrapping modulo NUM_REQ.
module cbus_arbiter_rr_pick import cbus_arbiter_pkg::*; #(
  parameter int NUM_REQ = 2,
  localparam int IW = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [IW-1:0]      idx_o,
  output logic               any_o
);

  int cand;

  // Walk from the farthest candidate to the nearest so the nearest valid wins.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    cand  = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = int'(ptr_i) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (valid_i[cand[IW-1:0]]) begin
        idx_o = cand[IW-1:0];
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cbus_arbiter.sv
// Cache-bus arbiter: grants one requester a whole burst on the shared memory
// bus, with an IDLE gap between bursts and optional round-robin fairness.
module cbus_arbiter import cbus_arbiter_pkg::*; #(
  parameter int NUM_REQ   = 2,
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  cbus_arbiter_if.master bus
);

  localparam int IW = idx_w(NUM_REQ);

  arb_state_t         state_q, state_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      ptr_eff;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic               burst_done;
  logic [NUM_REQ-1:0] req_valid;
  cbus_req_t          oreq_c;
  cbus_resp_t         oresps_c [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_valid
    assign req_valid[g]  = bus.ireqs[g].valid;
    assign bus.oresps[g] = oresps_c[g];
  end

  assign ptr_eff    = RR_ENABLE ? ptr_q : '0;
  assign burst_done = bus.iresp.ready & bus.iresp.last;

  cbus_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid_i (req_valid),
    .ptr_i   (ptr_eff),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  // Outputs depend only on the registered state, so IDLE always shows a
  // zero request and a fresh grant appears one cycle after arbitration.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    oreq_c  = '0;
    for (int i = 0; i < NUM_REQ; i++) oresps_c[i] = '0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          owner_d = pick_idx;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        oreq_c            = bus.ireqs[owner_q];
        oresps_c[owner_q] = bus.iresp;
        if (burst_done) begin
          state_d = ARB_IDLE;
          if (RR_ENABLE) begin
            ptr_d = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);
          end else begin
            ptr_d = '0;
          end
        end
      end
    endcase
  end

  assign bus.oreq  = oreq_c;
  assign bus.owner = owner_q;
  assign bus.busy  = (state_q == ARB_BUSY);
  assign bus.state = state_q;

endmodule

// File: tb/tb_cbus_arbiter.sv
// Bench for cbus_arbiter: one round-robin and one fixed-priority instance fed
// the same directed stimulus, checked against a burst-level model every cycle.
module tb_cbus_arbiter;
  import cbus_arbiter_pkg::*;

  localparam int N = 2;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  cbus_req_t  reqs [N];
  cbus_resp_t resp;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state, index 0 = round-robin instance, 1 = fixed-priority instance.
  bit m_busy  [2];
  int m_owner [2];
  int m_ptr   [2];

  int er [4] = '{0, 1, 0, 1};

  always #5 clk = ~clk;

  cbus_arbiter_if #(.NUM_REQ(N)) bus_rr ();
  cbus_arbiter_if #(.NUM_REQ(N)) bus_fp ();

  for (genvar g = 0; g < N; g++) begin : g_drv
    assign bus_rr.ireqs[g] = reqs[g];
    assign bus_fp.ireqs[g] = reqs[g];
  end
  assign bus_rr.iresp = resp;
  assign bus_fp.iresp = resp;

  cbus_arbiter #(.NUM_REQ(N), .RR_ENABLE(1'b1)) dut_rr (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_rr)
  );

  cbus_arbiter #(.NUM_REQ(N), .RR_ENABLE(1'b0)) dut_fp (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_fp)
  );

  // ---------------- clock/reset helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  always @(posedge clk or posedge reset) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_busy[d]  = 1'b0;
        m_owner[d] = 0;
        m_ptr[d]   = 0;
      end else if (!m_busy[d]) begin
        bit found;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_ptr[d] + k) % N;
          if (!found && reqs[c].valid) begin
            found      = 1'b1;
            m_owner[d] = c;
            m_busy[d]  = 1'b1;
          end
        end
      end else if (resp.ready && resp.last) begin
        m_busy[d] = 1'b0;
        m_ptr[d]  = (d == 0) ? (m_owner[d] + 1) % N : 0;
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  task automatic cmp_dut(input int d, input cbus_req_t a_oreq, input cbus_resp_t a_r0,
                         input cbus_resp_t a_r1, input logic a_owner, input logic a_busy,
                         input arb_state_t a_state);
    string p;
    cbus_req_t  e_oreq;
    cbus_resp_t e_r0, e_r1;
    p      = (d == 0) ? "rr" : "fp";
    e_oreq = '0;
    e_r0   = '0;
    e_r1   = '0;
    if (m_busy[d]) begin
      e_oreq = reqs[m_owner[d]];
      if (m_owner[d] == 0) e_r0 = resp;
      else                 e_r1 = resp;
    end
    chk({p, "_oreq"},   128'(a_oreq), 128'(e_oreq));
    chk({p, "_oresp0"}, 128'(a_r0),   128'(e_r0));
    chk({p, "_oresp1"}, 128'(a_r1),   128'(e_r1));
    chk({p, "_owner"},  128'(a_owner), 128'(m_owner[d]));
    chk({p, "_busy"},   128'(a_busy),  128'(m_busy[d]));
    chk({p, "_state"},  128'(a_state == ARB_BUSY), 128'(m_busy[d]));
  endtask

  always @(negedge clk) begin
    cmp_dut(0, bus_rr.oreq, bus_rr.oresps[0], bus_rr.oresps[1], bus_rr.owner, bus_rr.busy, bus_rr.state);
    cmp_dut(1, bus_fp.oreq, bus_fp.oresps[0], bus_fp.oresps[1], bus_fp.owner, bus_fp.busy, bus_fp.state);
  end

  // ---------------- driver tasks ----------------
  function automatic cbus_req_t mk_req(input logic [31:0] addr, input logic [3:0] len);
    cbus_req_t r;
    r          = '0;
    r.valid    = 1'b1;
    r.size     = 3'd3;
    r.addr     = addr;
    r.strobe   = 8'hff;
    r.data     = {32'hCAFE0000, addr};
    r.len      = len;
    return r;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    resp  = '0;
    for (int i = 0; i < N; i++) reqs[i] = '0;
    mid();
    chk("rst_rr_busy",   bus_rr.busy, 0);
    chk("rst_rr_owner",  bus_rr.owner, 0);
    chk("rst_rr_oreq",   128'(bus_rr.oreq), 0);
    chk("rst_rr_oresp0", 128'(bus_rr.oresps[0]), 0);
    chk("rst_fp_busy",   bus_fp.busy, 0);
    chk("rst_fp_oreq",   128'(bus_fp.oreq), 0);
    cyc();
    reset = 1'b0;
  endtask

  // One memory beat; checks literal grant/forwarding expectations on both instances.
  task automatic beat(input int b, input bit lst, input int own_rr, input int own_fp);
    cbus_resp_t r_own, r_oth;
    resp.ready = 1'b1;
    resp.last  = lst;
    resp.data  = 64'hD00D_0000_0000_0000 + 64'(b);
    mid();
    r_own = (own_rr == 0) ? bus_rr.oresps[0] : bus_rr.oresps[1];
    r_oth = (own_rr == 0) ? bus_rr.oresps[1] : bus_rr.oresps[0];
    chk("beat_rr_busy",        bus_rr.busy, 1);
    chk("beat_rr_owner",       bus_rr.owner, own_rr);
    chk("beat_rr_fwd_ready",   r_own.ready, 1);
    chk("beat_rr_fwd_last",    r_own.last, lst);
    chk("beat_rr_fwd_data",    r_own.data, 64'hD00D_0000_0000_0000 + 64'(b));
    chk("beat_rr_other_ready", r_oth.ready, 0);
    chk("beat_rr_addr",        bus_rr.oreq.addr, reqs[own_rr].addr);
    chk("beat_rr_valid",       bus_rr.oreq.valid, reqs[own_rr].valid);
    r_own = (own_fp == 0) ? bus_fp.oresps[0] : bus_fp.oresps[1];
    r_oth = (own_fp == 0) ? bus_fp.oresps[1] : bus_fp.oresps[0];
    chk("beat_fp_busy",        bus_fp.busy, 1);
    chk("beat_fp_owner",       bus_fp.owner, own_fp);
    chk("beat_fp_fwd_ready",   r_own.ready, 1);
    chk("beat_fp_other_ready", r_oth.ready, 0);
    cyc();
  endtask

  task automatic idle_check(input string tag);
    mid();
    chk({tag, "_rr_busy"},  bus_rr.busy, 0);
    chk({tag, "_fp_busy"},  bus_fp.busy, 0);
    chk({tag, "_rr_valid"}, bus_rr.oreq.valid, 0);
    cyc();
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    do_reset();

    // Single requester, 4-beat burst, grant one cycle after request.
    reqs[0] = mk_req(32'h1000, 4'd3);
    mid();
    chk("A_arb_rr_busy",  bus_rr.busy, 0);
    chk("A_arb_rr_valid", bus_rr.oreq.valid, 0);
    cyc();
    for (int b = 0; b < 4; b++) beat(b, b == 3, 0, 0);
    resp = '0;
    reqs[0].valid = 1'b0;
    chk("A_model_busy", m_busy[0], 0);
    chk("A_model_ptr",  m_ptr[0], 1);
    idle_check("A_idle");

    // Both requesting: round-robin alternates, fixed priority keeps 0.
    do_reset();
    reqs[0] = mk_req(32'h2000, 4'd1);
    reqs[1] = mk_req(32'h3000, 4'd1);
    cyc();
    for (int k = 0; k < 4; k++) begin
      chk("B_model_rr_owner", m_owner[0], er[k]);
      chk("B_model_fp_owner", m_owner[1], 0);
      beat(0, 1'b0, er[k], 0);
      beat(1, 1'b1, er[k], 0);
      resp = '0;
      if (k == 3) begin
        reqs[0].valid = 1'b0;
        reqs[1].valid = 1'b0;
      end
      idle_check("B_gap");
    end

    // Isolation while 1 owns; 0 rises in the final beat and wins next.
    do_reset();
    reqs[1] = mk_req(32'h4000, 4'd2);
    cyc();
    beat(0, 1'b0, 1, 1);
    beat(1, 1'b0, 1, 1);
    reqs[0] = mk_req(32'h5000, 4'd0);
    beat(2, 1'b1, 1, 1);
    resp = '0;
    idle_check("C_gap");
    reqs[1].valid = 1'b0;
    beat(0, 1'b1, 0, 0);
    resp = '0;
    reqs[0].valid = 1'b0;
    idle_check("C_end");

    // Owner drops valid mid-burst: stays granted, forwards valid=0.
    do_reset();
    reqs[0] = mk_req(32'h7000, 4'd3);
    cyc();
    beat(0, 1'b0, 0, 0);
    beat(1, 1'b0, 0, 0);
    reqs[0].valid = 1'b0;
    beat(2, 1'b0, 0, 0);
    beat(3, 1'b1, 0, 0);
    resp = '0;
    idle_check("D_end");

    // Reset pulse during beat 2 of an 8-beat burst, then a normal grant.
    do_reset();
    reqs[0] = mk_req(32'h6000, 4'd7);
    cyc();
    beat(0, 1'b0, 0, 0);
    resp.ready = 1'b1;
    resp.last  = 1'b0;
    resp.data  = 64'hD00D_0000_0000_0001;
    #1 reset = 1'b1;
    #1;
    chk("E_rst_rr_busy",   bus_rr.busy, 0);
    chk("E_rst_rr_valid",  bus_rr.oreq.valid, 0);
    chk("E_rst_rr_ready0", bus_rr.oresps[0].ready, 0);
    chk("E_rst_fp_busy",   bus_fp.busy, 0);
    chk("E_rst_fp_ready0", bus_fp.oresps[0].ready, 0);
    chk("E_model_busy",    m_busy[0], 0);
    #1 reset = 1'b0;
    mid();
    chk("E_post_rst_busy", bus_rr.busy, 0);
    cyc();
    for (int b = 0; b < 8; b++) beat(b, b == 7, 0, 0);
    resp = '0;
    reqs[0].valid = 1'b0;
    idle_check("E_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
